// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared types and constants for the data-memory access controller.
//            Access-size codes, controller state encoding, requester index.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // Access-size codes carried on mN_size; 2'b00 is never a legal access.
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dm_state_e;

  // Requester index: 0 = pipeline MEM stage, 1 = debug/DMA.
  typedef logic port_idx_t;

endpackage
`default_nettype wire

// File: rtl/dm_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : dm_lane_unit
// Purpose  : Combinational byte-lane logic for 32-bit data memory accesses.
//            Produces byte enables, lane-replicated store data, extracted and
//            extended load data, and an illegal/misaligned flag.
// Ports    : i_offs     - byte offset within the word (addr[1:0])
//            i_size     - access size code
//            i_sext     - sign-extend loads when 1
//            i_wdata    - right-justified store data
//            i_rdata    - raw RAM read word
//            o_be       - byte enables
//            o_wdata    - replicated store word
//            o_rdata    - extracted/extended load result
//            o_misalign - access is misaligned or of illegal size
// Revision : 1.0 - initial release
// ============================================================================
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  i_offs,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = 32'h0;
    o_rdata    = 32'h0;
    o_misalign = 1'b1;
    w_byte     = i_rdata[{i_offs, 3'b000} +: 8];
    w_half     = i_offs[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: begin
        o_be       = 4'b0001 << i_offs;
        o_wdata    = {4{i_wdata[7:0]}};
        o_rdata    = {{24{i_sext & w_byte[7]}}, w_byte};
        o_misalign = 1'b0;
      end
      SZ_HALF: begin
        o_be       = i_offs[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{i_sext & w_half[15]}}, w_half};
        o_misalign = i_offs[0];
      end
      SZ_WORD: begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        o_misalign = (i_offs != 2'b00);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_ctrl
// Purpose  : Data-memory access controller between the MEM stage (port 0) and
//            debug/DMA (port 1) and a wait-stated data RAM. Round-robin
//            arbitration, one RAM transaction at a time, rejection of
//            misaligned/illegal accesses without touching memory.
// Ports    : clk, rst_n            - clock, async active-low reset
//            mN_req/we/size/sext/addr/wdata - requester N command (held to done)
//            mN_gnt                - accept strobe (combinational, IDLE only)
//            mN_done/err/rdata     - registered completion, error, load data
//            mem_en/we/be/addr/wdata - RAM command, valid while mem_en
//            mem_rdata, mem_ack    - RAM response
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic          m0_sext,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic          m1_sext,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  dm_state_e     r_state;
  port_idx_t     r_last;
  port_idx_t     r_port;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_done;
  logic [1:0]    r_err;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;

  logic          w_idle;
  logic          w_any;
  port_idx_t     w_sel;
  logic          w_in_we;
  logic [1:0]    w_in_size;
  logic          w_in_sext;
  logic [AW-1:0] w_in_addr;
  logic [31:0]   w_in_wdata;
  logic [1:0]    w_offs;
  logic [1:0]    w_size;
  logic [3:0]    w_be;
  logic [31:0]   w_st_data;
  logic [31:0]   w_ld_data;
  logic          w_misalign;

  // Arbitration: on a tie the port that was not granted last wins.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_any      = m0_req | m1_req;
    w_sel      = (m0_req & m1_req) ? ~r_last : m1_req;
    w_in_we    = w_sel ? m1_we    : m0_we;
    w_in_size  = w_sel ? m1_size  : m0_size;
    w_in_sext  = w_sel ? m1_sext  : m0_sext;
    w_in_addr  = w_sel ? m1_addr  : m0_addr;
    w_in_wdata = w_sel ? m1_wdata : m0_wdata;
  end

  assign m0_gnt = w_idle & m0_req & ~w_sel;
  assign m1_gnt = w_idle & m1_req &  w_sel;

  // One lane unit serves both phases: in IDLE it judges the incoming winner's
  // legality, afterwards it works from the captured command.
  assign w_offs = w_idle ? w_in_addr[1:0] : r_addr[1:0];
  assign w_size = w_idle ? w_in_size      : r_size;

  dm_lane_unit u_lane (
    .i_offs     (w_offs),
    .i_size     (w_size),
    .i_sext     (r_sext),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_sext   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last  <= w_sel;
            r_port  <= w_sel;
            r_we    <= w_in_we;
            r_size  <= w_in_size;
            r_sext  <= w_in_sext;
            r_addr  <= w_in_addr;
            r_wdata <= w_in_wdata;
            if (w_misalign) begin
              r_done[w_sel] <= 1'b1;
              r_err[w_sel]  <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!r_we) begin
              if (r_port) r_rdata1 <= w_ld_data;
              else        r_rdata0 <= w_ld_data;
            end
            r_done[r_port] <= 1'b1;
            r_state        <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM command decodes straight from the state register so an async reset
  // removes it without waiting for a clock edge.
  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_be    = mem_en ? w_be : 4'b0000;
  assign mem_addr  = mem_en ? {r_addr[AW-1:2], 2'b00} : '0;
  assign mem_wdata = (mem_en & r_we) ? w_st_data : 32'h0;

  assign m0_done  = r_done[0];
  assign m1_done  = r_done[1];
  assign m0_err   = r_err[0];
  assign m1_err   = r_err[1];
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_ctrl
// Purpose  : Self-checking bench for dm_access_ctrl: directed scenarios plus
//            randomized two-port traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       we = '0;
  logic [1:0]       sext = '0;
  logic [1:0][1:0]  size = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [1:0]       err;
  logic [31:0]      rdata0;
  logic [31:0]      rdata1;
  logic             mem_en;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = '0;
  logic             mem_ack = 1'b0;

  int          waits [2];
  logic [31:0] rd_word [2];
  logic [31:0] exp_rd [2];
  int          last_port = 1;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_size(size[0]), .m0_sext(sext[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(gnt[0]), .m0_done(done[0]), .m0_err(err[0]), .m0_rdata(rdata0),
    .m1_req(req[1]), .m1_we(we[1]), .m1_size(size[1]), .m1_sext(sext[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(gnt[1]), .m1_done(done[1]), .m1_err(err[1]), .m1_rdata(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // ---- reference model: access rules in plain arithmetic ----
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 0 : (1 << (int'(s) - 1));
  endfunction

  function automatic bit is_legal(input logic [1:0] s, input logic [31:0] a);
    int nb = nbytes(s);
    return (nb != 0) && ((a % nb) == 0);
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] s, input logic [31:0] a);
    int nb = nbytes(s);
    return ((1 << nb) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] exp_st(input logic [1:0] s, input logic [31:0] d);
    int nb = nbytes(s);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [1:0] s, input logic sx,
                                         input logic [31:0] a, input logic [31:0] w);
    int nb = nbytes(s);
    longint unsigned mask;
    longint unsigned v;
    if (nb == 4) return w;
    mask = (64'd1 << (8 * nb)) - 1;
    v = (longint'(w) >> (8 * (a % 4))) & mask;
    if (sx && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] port_rdata(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  task automatic set_req(input int p, input logic w, input logic [1:0] s, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input int ws,
                         input logic [31:0] rw);
    we[p] = w; size[p] = s; sext[p] = sx; addr[p] = a; wdata[p] = d;
    waits[p] = ws; rd_word[p] = rw; req[p] = 1'b1;
  endtask

  task automatic rand_req(input int p);
    logic [1:0] s;
    logic [31:0] a;
    int nb;
    s = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    a = $urandom;
    nb = nbytes(s);
    if (nb > 1 && $urandom_range(0, 2) != 0) a = a & ~(32'(nb) - 1);
    set_req(p, 1'($urandom), s, 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom);
  endtask

  // Entered at a negedge while the controller is idle with a request pending;
  // returns at the negedge of the following idle cycle.
  task automatic serve(output int served);
    int w, o, t;
    bit lg;
    t = 0;
    #1;
    while (gnt == 2'b00 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (gnt == 2'b00) begin
      check("gnt_timeout", 0, 1);
      finish_tb();
    end
    check("accept_latency", t, 0);
    w = (req == 2'b11) ? (1 - last_port) : (req[1] ? 1 : 0);
    o = 1 - w;
    served = w;
    check("gnt_winner", {30'b0, gnt}, 32'(1 << w));
    check("mem_en_idle", {31'b0, mem_en}, 0);
    lg = is_legal(size[w], addr[w]);
    last_port = w;
    @(negedge clk); #1;
    if (!lg) begin
      check("illegal_no_mem_en", {31'b0, mem_en}, 0);
      check("illegal_done", {30'b0, done}, 32'(1 << w));
      check("illegal_err", {30'b0, err}, 32'(1 << w));
    end else begin
      for (int k = 0; k <= waits[w]; k++) begin
        check("mem_en", {31'b0, mem_en}, 1);
        check("mem_we", {31'b0, mem_we}, {31'b0, we[w]});
        check("mem_be", {28'b0, mem_be}, exp_be(size[w], addr[w]));
        check("mem_addr", mem_addr, addr[w] & 32'hFFFF_FFFC);
        if (we[w]) check("mem_wdata", mem_wdata, exp_st(size[w], wdata[w]));
        check("done_early", {30'b0, done}, 0);
        mem_ack = (k == waits[w]);
        mem_rdata = (k == waits[w]) ? rd_word[w] : $urandom;
        @(negedge clk); #1;
      end
      mem_ack = 1'b0;
      check("mem_en_after_ack", {31'b0, mem_en}, 0);
      check("done", {30'b0, done}, 32'(1 << w));
      check("err_clear", {30'b0, err}, 0);
      if (!we[w]) exp_rd[w] = exp_ld(size[w], sext[w], addr[w], rd_word[w]);
    end
    check("rdata_served", port_rdata(w), exp_rd[w]);
    check("rdata_other", port_rdata(o), exp_rd[o]);
    req[w] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int sp;
    exp_rd[0] = '0; exp_rd[1] = '0;
    waits[0] = 0; waits[1] = 0;
    rd_word[0] = '0; rd_word[1] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_mem_be", {28'b0, mem_be}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_done", {30'b0, done}, 0);
    check("rst_err", {30'b0, err}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte store, zero wait states
    set_req(0, 1'b1, 2'b01, 1'b0, 32'h103, 32'hAB, 0, 32'h0);
    serve(sp);
    // Half load, sign-extend, two wait states
    set_req(1, 1'b0, 2'b10, 1'b1, 32'h202, 32'h0, 2, 32'h8001_1234);
    serve(sp);
    check("tp_half_sext", rdata1, 32'hFFFF_8001);
    // Misaligned word, then illegal size
    set_req(0, 1'b0, 2'b11, 1'b0, 32'h301, 32'h0, 0, 32'h0);
    serve(sp);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 0, 32'h0);
    serve(sp);
    // Byte load, zero-extend
    set_req(0, 1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 1, 32'h0000_F200);
    serve(sp);
    check("tp_byte_zext", rdata0, 32'h0000_00F2);

    // Reset while RAM is stalling
    set_req(0, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 9, 32'h0);
    #1;
    check("rst_test_gnt", {30'b0, gnt}, 1);
    @(negedge clk); #1;
    check("rst_test_mem_en", {31'b0, mem_en}, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_en", {31'b0, mem_en}, 0);
    check("async_rst_done", {30'b0, done}, 0);
    req = 2'b00;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_port = 1;
    @(negedge clk); #1;
    check("rst_abort_done", {30'b0, done}, 0);
    check("rst_abort_rdata0", rdata0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both ports continuously requesting: strict alternation from port 0
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 4; i++) begin
      serve(sp);
      check("rr_order", sp, i % 2);
      rand_req(sp);
    end
    req = 2'b00;

    // Randomized two-port traffic
    for (int i = 0; i < 80; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 3) != 0) rand_req(p);
      if (req == 2'b00) rand_req(int'($urandom_range(0, 1)));
      serve(sp);
    end

    finish_tb();
  end

endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access controller placed between the MEM stage and the data RAM. Arbitrates two requesters (port 0: pipeline MEM stage, port 1: debug/DMA) with round-robin priority, sequences one multi-cycle RAM transaction at a time with a wait-state handshake, generates byte enables and lane-replicated store data, and returns extracted, sign- or zero-extended load data. Misaligned or illegal-size accesses are rejected without touching memory.

## Interface
- `AW`, default 32: byte-address width; `mem_addr` carries `AW` bits, low 2 bits forced to 0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mN_req` in 1 (N = 0, 1): request; held with all `mN_*` fields stable until `mN_done`.
- `mN_we` in 1: 1 = store, 0 = load.
- `mN_size` in 2: 01 byte, 10 half, 11 word, 00 illegal.
- `mN_sext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `mN_addr` in AW: byte address.
- `mN_wdata` in 32: store data, right-justified.
- `mN_gnt` out 1: combinational; high in the IDLE cycle that port N is accepted.
- `mN_done` out 1: registered one-cycle completion pulse.
- `mN_err` out 1: valid with `mN_done`; 1 = misaligned/illegal, no memory access made.
- `mN_rdata` out 32: load result, valid with `mN_done`, held until next completion for that port.
- `mem_en` out 1, `mem_we` out 1, `mem_be` out 4, `mem_addr` out AW, `mem_wdata` out 32: RAM command, stable while `mem_en`.
- `mem_rdata` in 32, `mem_ack` in 1: RAM response; `mem_ack` may arrive in the first `mem_en` cycle.

## Operation
- FSM: IDLE, ACCESS, DONE.
- IDLE: if any `req`, select winner, assert its `gnt`, capture we/size/sext/addr/wdata/port into registers. Legal -> ACCESS; illegal -> DONE with err.
- Round robin: `last` pointer (reset = 1, so port 0 wins first tie). Both requesting -> grant port != `last`; single request -> grant it. `last` updates on every grant.
- Legal: byte any offset; half with addr[0]=0; word with addr[1:0]=00. Size 00 always illegal.
- ACCESS: `mem_en`=1 until `mem_ack`; on ack capture lane result, go DONE.
- Byte enables: byte -> one-hot of addr[1:0] (00->0001 ... 11->1000); half -> 0011 (offset 00) / 1100 (offset 10); word -> 1111. Loads drive the same `mem_be`.
- Store data: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
- Load: select lane by addr[1:0]; extend to 32 bits per `sext`. Word ignores `sext`.
- DONE: pulse `done` (and `err` if applicable) on captured port for one cycle; no requests sampled; -> IDLE. Requester drops `req` on the edge it sees `done`.
- Stores complete with `rdata` unchanged.

## Timing
- Accept at cycle T; `mem_en` high T+1..ack cycle; `done` one cycle after ack. Zero wait states: `done` at T+2, next accept at T+3.
- Illegal: `done`+`err` at T+1, `mem_en` never asserted.
- Each extra RAM wait state adds one cycle; no timeout.
- Losing port's `gnt` stays low; it is served in the earliest following IDLE.
- Reset values: FSM IDLE, `last`=1, all outputs 0 (`mem_en`, `done`, `err`, `rdata`, `mem_*`). Reset mid-ACCESS drops `mem_en` immediately; transaction aborted, no `done`.

## Structure
- Package `dm_pkg`: size codes SZ_BYTE=01, SZ_HALF=10, SZ_WORD=11; FSM state enum; port-index type.
- Sub-module `dm_lane_unit` (combinational): addr[1:0] + size -> `mem_be`, store replication, load extract/extend, misalignment flag. FSM and arbiter stay in `dm_access_ctrl`.

## Test plan
- Port 0 store byte, addr 0x103, wdata 0xAB, ack same cycle -> `mem_be`=1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x100, `m0_done` at T+2, err 0.
- Port 1 load half sext, addr 0x202, `mem_rdata`=0x8001_1234, 2 wait states -> `mem_be`=1100, `m1_rdata`=0xFFFF8001 at T+4.
- Both request from reset, back-to-back -> grants m0, m1, m0, m1; no port starved.
- Word load at addr 0x301 -> `m0_done`+`m0_err` at T+1, `mem_en` never high; size 00 -> same.
- Byte load zero-extend, addr 0x001, `mem_rdata`=0x0000_F200 -> `rdata`=0x000000F2.
- `rst_n` low during ACCESS wait -> `mem_en` 0 asynchronously, no `done`; after release, port 0 wins first tie.
